// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core types and constants
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Major opcodes, shared with decode
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_data    write request and data
//   i_pop             read request; o_data is the head, valid while !o_empty
//   i_flush           discard all entries (wins over push; pop is irrelevant)
//   o_count           number of stored entries (0..DEPTH)
//   o_full, o_empty   status flags
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch stage: PC, imem request issue, in-order instruction queue
//
// Ports:
//   clk, rst_n                        core clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr   word-aligned read requests to instruction memory
//   imem_rsp_valid, imem_rsp_data     in-order read responses, latency >= 1
//   redirect_valid, redirect_pc       PC change from execute (one-cycle pulse)
//   if_valid/ready, if_instr, if_pc   queue head handed to decode
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int              FIFO_DEPTH   = 4,
    parameter int              MAX_OUTST    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int QCW = $clog2(FIFO_DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUTST + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + MAX_OUTST + 1);

    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;
    logic            r_run;

    logic            w_issue;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_pop;
    logic            w_credit_ok;
    logic [OW-1:0]   w_outst_live;
    logic [OW-1:0]   w_outst_next;

    fetch_pkt_t      w_q_wdata;
    fetch_pkt_t      w_q_head;
    logic [QCW-1:0]  w_q_count;
    logic            w_q_full;
    logic            w_q_empty;

    logic [XLEN-1:0] w_tag_pc;
    logic [TCW-1:0]  w_tag_count;
    logic            w_tag_full;
    logic            w_tag_empty;

    // Response with nothing outstanding is a protocol error and is ignored
    assign w_rsp        = imem_rsp_valid && (r_outst != '0);
    assign w_rsp_keep   = w_rsp && (r_drop == '0) && !redirect_valid;
    assign w_pop        = if_valid && if_ready;
    assign w_issue      = imem_req_valid && imem_req_ready;
    assign w_outst_live = r_outst - r_drop;
    assign w_outst_next = r_outst + OW'(w_issue) - OW'(w_rsp);

    // Every live request owns a queue slot before it is issued, so a response
    // always finds room and memory never needs back-pressure.
    assign w_credit_ok    = (SW'(w_q_count) + SW'(w_outst_live)) < SW'(FIFO_DEPTH);
    assign imem_req_valid = r_run && !redirect_valid
                            && (r_outst < OW'(MAX_OUTST)) && w_credit_ok;
    assign imem_addr      = r_pc;

    assign if_valid = !w_q_empty;
    assign if_instr = if_valid ? w_q_head.instr : '0;
    assign if_pc    = if_valid ? w_q_head.pc    : '0;

    assign w_q_wdata = '{instr: imem_rsp_data, pc: w_tag_pc};

    // r_run holds off requests for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_outst <= '0;
            r_drop  <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_outst <= w_outst_next;
            if (redirect_valid) begin
                r_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
                // Everything still in flight after this edge belongs to the old path
                r_drop <= w_outst_next;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - OW'(1);
                end
            end
        end
    end

    // PC tags of live requests, in issue order; dropped responses never pop it
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST),
        .CW    (TCW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_issue),
        .i_data  (r_pc),
        .i_pop   (w_rsp_keep),
        .i_flush (redirect_valid),
        .o_data  (w_tag_pc),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (QCW)
    ) u_instr_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_keep),
        .i_data  (w_q_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_q_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    logic w_unused;
    assign w_unused = ^{w_tag_count, w_tag_full, w_tag_empty, w_q_full, redirect_pc[1:0]};

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outst != '0));

    a_drop_le_outst: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop <= r_outst);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV        = 32'h0000_0000;
    localparam int          QDEPTH    = 4;
    localparam int          MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    instruction_fetch_unit #(
        .RESET_VECTOR (RV),
        .FIFO_DEPTH   (QDEPTH),
        .MAX_OUTST    (MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        int          lat_lo;
        int          lat_hi;
        int          rdy_pct;
        int          ifr_pct;
        logic [31:0] tgt;
        logic [31:0] exp_first;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    pend_t       pend[$];
    int          last_due = 0;

    // Reference model: decode must see a gap-free +4 sequence from the last target
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;

    int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, ifr_pct = 100, redir_pct = 0;
    logic        f_redir = 1'b0;
    logic [31:0] f_redir_pc = '0;
    logic        redir_on_both = 1'b0;
    logic [31:0] both_tgt = '0;
    logic        both_hit = 1'b0;

    int          n_issue = 0;
    int          n_deliv = 0;
    logic [31:0] last_deliv_pc = '0;
    logic [31:0] last_issue_addr = '0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int lat;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom % 100) < rdy_pct;
        if_ready       = ($urandom % 100) < ifr_pct;
        if (f_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = f_redir_pc;
            f_redir        = 1'b0;
        end else if (redir_on_both && imem_rsp_valid && if_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = both_tgt;
            redir_on_both  = 1'b0;
            both_hit       = 1'b1;
        end else begin
            redirect_valid = ($urandom % 100) < redir_pct;
            redirect_pc    = $urandom;
        end
        #1;
        if (hold_prev && !redirect_valid) begin
            chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("req_hold_addr", imem_addr, hold_addr);
        end
        if (redirect_valid) begin
            chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("imem_addr", imem_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            lat = $urandom_range(lat_hi, lat_lo);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
            pend.push_back('{addr: imem_addr, due: last_due});
            chk("outst_bound", {31'b0, pend.size() <= MAX_OUTST}, 32'd1);
            n_issue++;
            last_issue_addr = imem_addr;
        end
        if (if_valid && if_ready) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
            last_deliv_pc = if_pc;
        end
        if (redirect_valid) begin
            exp_pc   = {redirect_pc[31:2], 2'b00};
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
        hold_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
        hold_addr = imem_addr;
        cyc++;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1;
        check_reset_outputs();
        pend.delete();
        last_due      = 0;
        exp_pc        = RV;
        exp_addr      = RV;
        hold_prev     = 1'b0;
        f_redir       = 1'b0;
        redir_on_both = 1'b0;
        redir_pct     = 0;
        n_issue       = 0;
        n_deliv       = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("no_req_before_release_edge", {31'b0, imem_req_valid}, 32'd0);
    endtask

    task automatic wait_deliv(input string name, input int bound);
        int n0 = n_deliv;
        for (int i = 0; i < bound && n_deliv == n0; i++) step();
        chk(name, {31'b0, n_deliv != n0}, 32'd1);
    endtask

    vec_t vecs[5];
    int   n0;
    logic [31:0] a0, a1;

    initial begin
        vecs[0] = '{1, 1, 100, 100, 32'h0000_1000, 32'h0000_1000};
        vecs[1] = '{1, 4,  70,  60, 32'h0000_2003, 32'h0000_2000};
        vecs[2] = '{3, 3,  50, 100, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[3] = '{1, 5, 100,  30, 32'h0000_1236, 32'h0000_1234};
        vecs[4] = '{2, 6,  80,  80, 32'h0000_0041, 32'h0000_0040};

        // 1: single-cycle memory, full throughput
        lat_lo = 1; lat_hi = 1; rdy_pct = 100; ifr_pct = 100;
        reset_dut();
        step();
        chk("first_req_after_release", {31'b0, n_issue == 1}, 32'd1);
        chk("first_req_addr", last_issue_addr, RV);
        repeat (4) step();
        chk("first_deliv_pc", last_deliv_pc + 32'd4 - 32'd4 * n_deliv, RV);
        n0 = n_deliv;
        repeat (20) step();
        chk("throughput_1_per_cycle", n_deliv - n0, 32'd20);

        // 2: decode stalled, latency 3: credit limits issue to queue depth
        lat_lo = 3; lat_hi = 3; ifr_pct = 0;
        reset_dut();
        repeat (20) step();
        chk("stall_total_requests", n_issue, QDEPTH);
        chk("stall_queue_full_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_no_deliv", n_deliv, 32'd0);
        ifr_pct = 100;
        repeat (30) step();
        chk("stall_drain", {31'b0, n_deliv >= QDEPTH}, 32'd1);

        // 3: redirect with two outstanding
        lat_lo = 6; lat_hi = 6;
        reset_dut();
        for (int i = 0; i < 20 && pend.size() < 2; i++) step();
        chk("two_outstanding", pend.size(), 32'd2);
        f_redir = 1'b1; f_redir_pc = 32'h0000_0100;
        step();
        wait_deliv("redir100_deliv", 100);
        chk("redir100_first_pc", last_deliv_pc, 32'h0000_0100);

        // 4: redirect coinciding with response and pop
        lat_lo = 2; lat_hi = 2;
        reset_dut();
        both_tgt = 32'h0000_0080; both_hit = 1'b0; redir_on_both = 1'b1;
        for (int i = 0; i < 50 && !both_hit; i++) begin
            n0 = n_deliv;
            step();
        end
        chk("both_hit", {31'b0, both_hit}, 32'd1);
        chk("both_pop_delivered", n_deliv - n0, 32'd1);
        @(posedge clk);
        #1;
        chk("both_queue_empty", {31'b0, if_valid}, 32'd0);
        wait_deliv("redir80_deliv", 100);
        chk("redir80_first_pc", last_deliv_pc, 32'h0000_0080);

        // 5: back-to-back redirects, last wins
        reset_dut();
        repeat (6) step();
        f_redir = 1'b1; f_redir_pc = 32'h0000_0203;
        step();
        f_redir = 1'b1; f_redir_pc = 32'h0000_0400;
        step();
        wait_deliv("redir400_deliv", 100);
        chk("redir400_first_pc", last_deliv_pc, 32'h0000_0400);

        // 6: PC wrap, then reset mid-burst
        lat_lo = 1; lat_hi = 1;
        reset_dut();
        repeat (3) step();
        f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
        step();
        n0 = n_issue;
        for (int i = 0; i < 20 && n_issue == n0; i++) step();
        a0 = last_issue_addr;
        n0 = n_issue;
        for (int i = 0; i < 20 && n_issue == n0; i++) step();
        a1 = last_issue_addr;
        chk("wrap_addr0", a0, 32'hFFFF_FFFC);
        chk("wrap_addr1", a1, 32'h0000_0000);
        repeat (6) step();
        ifr_pct = 0;
        repeat (3) step();
        chk("burst_before_reset", {31'b0, if_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        ifr_pct = 100;

        // Randomized scenarios against the sequential-PC model
        foreach (vecs[k]) begin
            lat_lo = vecs[k].lat_lo; lat_hi = vecs[k].lat_hi;
            rdy_pct = vecs[k].rdy_pct; ifr_pct = vecs[k].ifr_pct;
            reset_dut();
            repeat (30) step();
            f_redir = 1'b1; f_redir_pc = vecs[k].tgt;
            step();
            wait_deliv("vec_deliv", 300);
            chk("vec_first_pc", last_deliv_pc, vecs[k].exp_first);
            redir_pct = 3;
            repeat (150) step();
            redir_pct = 0;
            ifr_pct = 100;
            repeat (20) step();
            chk("vec_progress", {31'b0, n_deliv > 0}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
